// File: rtl/mem_access_stage_pkg.sv
// Shared widths and state encoding for the data-memory access stage.
package mem_access_stage_pkg;

  localparam int unsigned DEF_WORD_LEN        = 16;
  localparam int unsigned DEF_INSTRUCTION_LEN = 16;
  localparam int unsigned DEF_ADDR_LEN        = 16;
  localparam int unsigned DEF_TIMEOUT         = 15;
  localparam int unsigned CNT_W               = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } mem_state_t;

endpackage

// File: rtl/mem_access_stage_wait_timer.sv
// Wait-cycle counter for an outstanding memory request; tc_c flags the last allowed cycle.
module mem_wait_timer
  import mem_access_stage_pkg::*;
#(
  parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc_c
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + CNT_W'(1);
    end
  end

  assign tc_c = (count == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_access_stage.sv
// Memory-access stage: turns EX/MEM load/store control into a req/ack data-memory
// transaction and stalls the pipeline until it completes or times out.
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int unsigned WORD_LEN = DEF_WORD_LEN,
  parameter int unsigned ADDR_LEN = DEF_ADDR_LEN,
  parameter int unsigned TIMEOUT  = DEF_TIMEOUT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                PR3_mem_read_en,
  input  logic                PR3_mem_write_en,
  input  logic [ADDR_LEN-1:0] PR3_alu_out,
  input  logic [WORD_LEN-1:0] PR3_RF_out2,
  output logic                dmem_req,
  output logic                dmem_we,
  output logic [ADDR_LEN-1:0] dmem_addr,
  output logic [WORD_LEN-1:0] dmem_wdata,
  input  logic [WORD_LEN-1:0] dmem_rdata,
  input  logic                dmem_ack,
  output logic [WORD_LEN-1:0] MEM_out,
  output logic                stall,
  output logic                bus_error
);

  mem_state_t state;
  logic       access_c;
  logic       timer_clr_c;
  logic       timer_en_c;
  logic       timer_tc_c;

  assign access_c    = PR3_mem_read_en | PR3_mem_write_en;
  assign timer_clr_c = (state == IDLE) && access_c;
  assign timer_en_c  = (state == REQ) && !dmem_ack && !timer_tc_c;

  // DONE deliberately drops stall so the pipeline advances exactly one step.
  assign stall = (state == REQ) || ((state == IDLE) && access_c);

  mem_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk  (clk),
    .rst  (rst),
    .clr  (timer_clr_c),
    .en   (timer_en_c),
    .tc_c (timer_tc_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      MEM_out    <= '0;
      bus_error  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (access_c) begin
            dmem_addr  <= PR3_alu_out;
            dmem_wdata <= PR3_RF_out2;
            dmem_we    <= PR3_mem_write_en;
            dmem_req   <= 1'b1;
            state      <= REQ;
          end
        end
        REQ: begin
          // Ack takes priority over a timeout landing in the same cycle.
          if (dmem_ack) begin
            if (!dmem_we) MEM_out <= dmem_rdata;
            dmem_req <= 1'b0;
            state    <= DONE;
          end else if (timer_tc_c) begin
            bus_error <= 1'b1;
            if (!dmem_we) MEM_out <= '0;
            dmem_req  <= 1'b0;
            state     <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
